// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM duty ramp controller: FSM state encoding and
// default duty limits/timing used as parameter defaults.
package pwm_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_e;

  localparam int unsigned DEF_DUTY_W   = 32;
  localparam int unsigned DEF_DC_MIN   = 5000;
  localparam int unsigned DEF_DC_MAX   = 150000;
  localparam int unsigned DEF_DC_RESET = 25000;
  localparam int unsigned DEF_STEP     = 2500;
  localparam int unsigned DEF_TICK_DIV = 2500000;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running 0..TICK_DIV-1 step-rate counter with synchronous restart; tick is
// high for the single cycle the counter sits on its terminal count.
module ramp_tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: steps duty_out toward an accepted target, one step
// per tick, applied only on PWM period boundaries. Define PWM_RAMP_RANGE_ERR_EN
// to reject (err pulse) out-of-range targets instead of clamping them.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_W   = DEF_DUTY_W,
  parameter int unsigned DC_MIN   = DEF_DC_MIN,
  parameter int unsigned DC_MAX   = DEF_DC_MAX,
  parameter int unsigned DC_RESET = DEF_DC_RESET,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              abort,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DUTY_W:0]   MIN_X   = (DUTY_W+1)'(DC_MIN);
  localparam logic [DUTY_W:0]   MAX_X   = (DUTY_W+1)'(DC_MAX);
  localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] RESET_D = DUTY_W'(DC_RESET);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic              tick, restart, apply;
  logic [DUTY_W:0]   duty_x, target_x, tgt_x, clamp_x, up_x, dn_x, next_x;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // All ramp arithmetic is one bit wider than the duty so nothing wraps.
  assign duty_x   = {1'b0, duty_q};
  assign target_x = {1'b0, target_q};
  assign tgt_x    = {1'b0, tgt_duty};
  assign clamp_x  = (tgt_x < MIN_X) ? MIN_X : ((tgt_x > MAX_X) ? MAX_X : tgt_x);
  assign up_x     = duty_x + STEP_X;
  assign dn_x     = (duty_x > STEP_X) ? (duty_x - STEP_X) : '0;
  assign next_x   = (state_q == UP) ? ((up_x > target_x) ? target_x : up_x)
                                    : ((dn_x < target_x) ? target_x : dn_x);
  assign apply    = period_end && (pending_q || tick);

`ifdef PWM_RAMP_RANGE_ERR_EN
  logic err_q, err_d;
  logic in_range;
  assign in_range = (tgt_x >= MIN_X) && (tgt_x <= MAX_X);
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    restart   = 1'b0;
`ifdef PWM_RAMP_RANGE_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
`ifdef PWM_RAMP_RANGE_ERR_EN
          if (!in_range) begin
            err_d = 1'b1;
          end else
`endif
          begin
            target_d  = clamp_x[DUTY_W-1:0];
            restart   = 1'b1;
            pending_d = 1'b0;
            if (clamp_x > duty_x) begin
              state_d = UP;
            end else if (clamp_x < duty_x) begin
              state_d = DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      UP, DOWN: begin
        if (abort) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end else if (apply) begin
          duty_d    = next_x[DUTY_W-1:0];
          pending_d = 1'b0;
          if (next_x == target_x) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      duty_q    <= RESET_D;
      target_q  <= RESET_D;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef PWM_RAMP_RANGE_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      done_q    <= done_d;
`ifdef PWM_RAMP_RANGE_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign duty_out  = duty_q;
  assign busy      = (state_q != IDLE);
  assign tgt_ready = (state_q == IDLE);
  assign done      = done_q;
`ifdef PWM_RAMP_RANGE_ERR_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: stimulus pushes expected duty/done/err
// events from a step-list model, a negedge monitor pops and compares them.
module tb_pwm_ramp_ctrl;

  localparam int DUTY_W   = 32;
  localparam int DC_MIN   = 5000;
  localparam int DC_MAX   = 150000;
  localparam int DC_RESET = 25000;
  localparam int STEP     = 2500;
  localparam int TICK_DIV = 4;
  localparam int PE_DIV   = 6;
  localparam int BUDGET   = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tgt_valid = 1'b0;
  logic [DUTY_W-1:0] tgt_duty = '0;
  logic              abort = 1'b0;
  logic              period_end = 1'b0;
  logic              tgt_ready, busy, done, err;
  logic [DUTY_W-1:0] duty_out;

  typedef enum int {EV_DUTY, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    longint   value;
  } ev_t;

  ev_t    exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint model_duty = DC_RESET;
  longint prev_duty  = DC_RESET;

  pwm_ramp_ctrl #(
    .DUTY_W(DUTY_W), .DC_MIN(DC_MIN), .DC_MAX(DC_MAX), .DC_RESET(DC_RESET),
    .STEP(STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_duty   (tgt_duty),
    .abort      (abort),
    .period_end (period_end),
    .duty_out   (duty_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // PWM generator stand-in: one-cycle period_end every PE_DIV clocks.
  initial begin
    forever begin
      repeat (PE_DIV - 1) @(posedge clk);
      #1 period_end = 1'b1;
      @(posedge clk);
      #1 period_end = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected nothing", name, act);
  endtask

  task automatic pop_check(input ev_kind_e kind, input longint value, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      fail_now({name, "_unexpected"}, value);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check(name, value, e.value);
    end
  endtask

  // Monitor: any duty change, done or err pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst) begin
      if (longint'(duty_out) != prev_duty) pop_check(EV_DUTY, duty_out, "duty_step");
      if (done) pop_check(EV_DONE, duty_out, "done_pulse");
      if (err)  pop_check(EV_ERR, duty_out, "err_pulse");
    end
    prev_duty = duty_out;
  end

  task automatic push_ev(input ev_kind_e kind, input longint value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // Reference: list of duty values from the current duty to the limited target.
  task automatic push_model(input longint tgt);
    longint t, d;
`ifdef PWM_RAMP_RANGE_ERR_EN
    if (tgt < DC_MIN || tgt > DC_MAX) begin
      push_ev(EV_ERR, model_duty);
      return;
    end
`endif
    t = (tgt < DC_MIN) ? DC_MIN : ((tgt > DC_MAX) ? DC_MAX : tgt);
    d = model_duty;
    while (d != t) begin
      if (t > d) d = (d + STEP < t) ? d + STEP : t;
      else       d = (d - STEP > t) ? d - STEP : t;
      push_ev(EV_DUTY, d);
    end
    push_ev(EV_DONE, t);
    model_duty = t;
  endtask

  // Hold tgt_valid until the handshake completes; returns at posedge+1 of the accept edge.
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (tgt_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      fail_now({name, "_accept_timeout"}, tgt_duty);
    end
    tgt_valid = 1'b0;
  endtask

  task automatic drive(input longint tgt);
    @(posedge clk);
    #1;
    tgt_valid = 1'b1;
    tgt_duty  = tgt[DUTY_W-1:0];
  endtask

  task automatic issue(input longint tgt, input string name);
    push_model(tgt);
    drive(tgt);
    wait_accept(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < BUDGET && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail_now({name, "_drain_timeout"}, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_busy"}, busy, 0);
    check({name, "_ready"}, tgt_ready, 1);
    check({name, "_duty"}, duty_out, model_duty);
  endtask

  initial begin
    longint t;
    int     c;

    #2 rst = 1'b0;
    #1;
    check("reset_duty", duty_out, DC_RESET);
    check("reset_busy", busy, 0);
    check("reset_ready", tgt_ready, 1);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed ramps: up, partial step, down, clamp (or reject) at both ends.
    issue(30000, "up");
    check("up_busy", busy, 1);
    check("up_ready", tgt_ready, 0);
    drain("up");
    issue(26000, "partial");
    drain("partial");
    issue(21000, "down");
    drain("down");
    issue(200000, "clamp_hi");
    drain("clamp_hi");
    issue(0, "clamp_lo");
    drain("clamp_lo");

    // Abort after the first applied step of 25000 -> 40000.
    issue(25000, "to_25k");
    drain("to_25k");
    push_ev(EV_DUTY, 27500);
    drive(40000);
    wait_accept("abort");
    check("abort_busy", busy, 1);
    for (int i = 0; i < BUDGET && duty_out == 25000; i++) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_ready", tgt_ready, 1);
    check("abort_busy_after", busy, 0);
    repeat (30) @(negedge clk);
    check("abort_hold", duty_out, 27500);
    check("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    model_duty = 27500;

    // Abort coincident with the first apply event: no update at all.
    drive(50000);
    wait_accept("abort_pe");
    c = 1;
    #1;
    while (!(c >= TICK_DIV && period_end) && c < 40) begin
      @(posedge clk);
      #2;
      c++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_pe_ready", tgt_ready, 1);
    check("abort_pe_duty", duty_out, 27500);
    repeat (30) @(negedge clk);
    check("abort_pe_hold", duty_out, 27500);

    // Target held while busy is only taken once the ramp completes.
    issue(60000, "hs_a");
    push_model(45000);
    drive(45000);
    @(negedge clk);
    check("hs_hold_ready", tgt_ready, 0);
    check("hs_hold_busy", busy, 1);
    wait_accept("hs_b");
    drain("hs_b");

    // Target equal to the current duty: done only, never busy.
    issue(model_duty, "equal");
    check("equal_busy", busy, 0);
    drain("equal");

    // Randomized targets, sometimes issued back-to-back while busy.
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: t = longint'($urandom_range(0, 160000));
        1: t = model_duty + longint'($urandom_range(0, 6000)) - 3000;
        2: t = model_duty;
        default: t = ($urandom_range(0, 1) != 0) ? longint'($urandom_range(140000, 170000))
                                                  : longint'($urandom_range(0, 10000));
      endcase
      issue(t, "rnd");
      if ($urandom_range(0, 1) != 0) drain("rnd");
    end
    drain("rnd_end");

    // Asynchronous reset in the middle of a ramp.
    issue(140000, "rst_ramp");
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_duty", duty_out, DC_RESET);
    check("midreset_busy", busy, 0);
    check("midreset_ready", tgt_ready, 1);
    exp_q.delete();
    model_duty = DC_RESET;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("midreset_done", done, 0);
    issue(30000, "post_reset");
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
